// File: rtl/aim_matcher_pkg.sv
// Shared state encoding, parameter defaults and helpers for the associative
// index matcher and its lane priority encoders.
package aim_pkg;
   localparam int W_BW_DEF    = 5;
   localparam int IA_CH_DEF   = 8;
   localparam int LANES_DEF   = 32;
   localparam int MAX_SEG_DEF = 8;
   localparam int POS_W_DEF   = $clog2(MAX_SEG_DEF * IA_CH_DEF);

   typedef logic [POS_W_DEF-1:0] pos_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_SEG,
      ST_COMP,
      ST_ENC,
      ST_COMMIT
   } aim_state_e;

   // Requests for more segments than a match position can address are truncated.
   function automatic int clamp_seg(input int num_seg, input int max_seg);
      return (num_seg > max_seg) ? max_seg : num_seg;
   endfunction
endpackage

// File: rtl/aim_matcher_prio_enc.sv
// Per-lane priority encoder: reports whether any channel matched and which one
// wins, lowest index first or highest index first.
module aim_prio_enc
   import aim_pkg::*;
#(
   parameter int IA_CH     = IA_CH_DEF,
   parameter bit MSB_FIRST = 1'b0,
   localparam int IDX_W    = (IA_CH > 1) ? $clog2(IA_CH) : 1
) (
   input  logic [IA_CH-1:0] map,
   output logic             hit,
   output logic [IDX_W-1:0] index
);

   // The loop direction makes the last assignment the winning channel.
   always_comb begin
      hit   = |map;
      index = '0;
      if (MSB_FIRST) begin
         for (int c = 0; c < IA_CH; c++) begin
            if (map[c]) index = c[IDX_W-1:0];
         end
      end else begin
         for (int c = IA_CH - 1; c >= 0; c--) begin
            if (map[c]) index = c[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/aim_matcher.sv
// Associative index matcher: compares a batch of weight words against streamed
// activation segments and commits per-word match flags/positions into a bank slot.
module aim_matcher
   import aim_pkg::*;
#(
   parameter int W_BW       = W_BW_DEF,
   parameter int LANES      = LANES_DEF,
   parameter int N_WORDS    = 256,
   parameter int IA_CH      = IA_CH_DEF,
   parameter int MAX_SEG    = MAX_SEG_DEF,
   parameter int MATCH_LAST = 0,
   parameter int POS_W      = $clog2(MAX_SEG * IA_CH),
   parameter int BATCH_W    = (N_WORDS / LANES > 1) ? $clog2(N_WORDS / LANES) : 1,
   localparam int NSEG_W    = $clog2(MAX_SEG) + 1,
   localparam int HITS_W    = $clog2(LANES) + 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_start,
   input  logic [BATCH_W-1:0]            i_batch,
   input  logic [NSEG_W-1:0]             i_num_seg,
   input  logic [LANES-1:0][W_BW-1:0]    i_word,
   input  logic                          i_ia_valid,
   output logic                          o_ia_ready,
   input  logic [IA_CH-1:0][W_BW-1:0]    i_ia,
   input  logic                          i_clear,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_err,
   output logic [HITS_W-1:0]             o_hits,
   output logic [N_WORDS-1:0]            o_valid,
   output logic [N_WORDS-1:0][POS_W-1:0] o_pos
);

   localparam int N_BATCH = N_WORDS / LANES;
   localparam int IDX_W   = (IA_CH > 1) ? $clog2(IA_CH) : 1;
   localparam int BASE_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam logic [NSEG_W-1:0] SEG_ONE = NSEG_W'(1);

   aim_state_e                  state;
   logic [LANES-1:0][W_BW-1:0]  word_q;
   logic [BATCH_W-1:0]          batch_q;
   logic [NSEG_W-1:0]           num_seg_q;
   logic [NSEG_W-1:0]           seg_cnt;
   logic [IA_CH-1:0][W_BW-1:0]  ia_q;
   logic [LANES-1:0][IA_CH-1:0] map_q;
   logic [LANES-1:0][IA_CH-1:0] map_d;
   logic [LANES-1:0]            scr_valid;
   logic [LANES-1:0][POS_W-1:0] scr_pos;
   logic [LANES-1:0]            enc_hit;
   logic [LANES-1:0][IDX_W-1:0] enc_idx;
   logic [LANES-1:0][POS_W-1:0] cand;
   logic [NSEG_W-1:0]           num_seg_clamped;
   logic                        batch_ok;
   logic [BASE_W-1:0]           slot_base;

   assign batch_ok        = (32'(i_batch) < 32'(N_BATCH));
   assign num_seg_clamped = NSEG_W'(clamp_seg(int'(i_num_seg), MAX_SEG));
   assign slot_base       = BASE_W'(32'(batch_q) * 32'(LANES));
   assign o_busy          = (state != ST_IDLE);
   assign o_ia_ready      = (state == ST_WAIT_SEG);

   always_comb begin
      map_d = '0;
      for (int j = 0; j < LANES; j++) begin
         for (int c = 0; c < IA_CH; c++) begin
            map_d[j][c] = (word_q[j] == ia_q[c]);
         end
      end
   end

   // Candidate position is the global channel index across all consumed segments.
   for (genvar j = 0; j < LANES; j++) begin : g_lane
      aim_prio_enc #(
         .IA_CH     (IA_CH),
         .MSB_FIRST (MATCH_LAST != 0)
      ) u_enc (
         .map   (map_q[j]),
         .hit   (enc_hit[j]),
         .index (enc_idx[j])
      );
      assign cand[j] = POS_W'(32'(seg_cnt) * 32'(IA_CH) + 32'(enc_idx[j]));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= ST_IDLE;
         word_q    <= '0;
         batch_q   <= '0;
         num_seg_q <= '0;
         seg_cnt   <= '0;
         ia_q      <= '0;
         map_q     <= '0;
         scr_valid <= '0;
         scr_pos   <= '0;
         o_valid   <= '0;
         o_pos     <= '0;
         o_hits    <= '0;
         o_done    <= 1'b0;
         o_err     <= 1'b0;
      end else begin
         o_done <= 1'b0;
         o_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_clear) begin
                  o_valid <= '0;
                  o_pos   <= '0;
                  o_hits  <= '0;
               end
               if (i_start) begin
                  if (batch_ok) begin
                     word_q    <= i_word;
                     batch_q   <= i_batch;
                     num_seg_q <= num_seg_clamped;
                     scr_valid <= '0;
                     scr_pos   <= '0;
                     seg_cnt   <= '0;
                     state     <= (num_seg_clamped == '0) ? ST_COMMIT : ST_WAIT_SEG;
                  end else begin
                     o_err <= 1'b1;
                  end
               end
            end
            ST_WAIT_SEG: begin
               if (i_ia_valid) begin
                  ia_q  <= i_ia;
                  state <= ST_COMP;
               end
            end
            ST_COMP: begin
               map_q <= map_d;
               state <= ST_ENC;
            end
            ST_ENC: begin
               // First-match lanes keep the earliest hit; last-match lanes keep overwriting.
               for (int j = 0; j < LANES; j++) begin
                  if (enc_hit[j] && ((MATCH_LAST != 0) || !scr_valid[j])) begin
                     scr_valid[j] <= 1'b1;
                     scr_pos[j]   <= cand[j];
                  end
               end
               seg_cnt <= seg_cnt + SEG_ONE;
               state   <= ((seg_cnt + SEG_ONE) == num_seg_q) ? ST_COMMIT : ST_WAIT_SEG;
            end
            ST_COMMIT: begin
               o_valid[slot_base +: LANES] <= scr_valid;
               o_pos[slot_base +: LANES]   <= scr_pos;
               o_hits <= HITS_W'($countones(scr_valid));
               o_done <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aim_matcher.sv
// Scoreboard bench for aim_matcher: one first-match and one last-match instance
// share stimulus; a monitor checks each commit against a model of the bank.
module tb_aim_matcher;

   logic                clk;
   logic                rst;
   logic                start;
   logic [3:0]          batch;
   logic [3:0]          num_seg;
   logic [31:0][4:0]    word;
   logic                ia_valid;
   logic [7:0][4:0]     ia;
   logic                clear;

   logic                ia_ready0, ia_ready1;
   logic                busy0, busy1;
   logic                done0, done1;
   logic                err0, err1;
   logic [5:0]          hits0, hits1;
   logic [255:0]        valid0, valid1;
   logic [255:0][5:0]   pos0, pos1;

   typedef struct {
      int               batch;
      int               done_cyc;
      logic [31:0]      vmask;
      logic [31:0][5:0] pf;
      logic [31:0][5:0] pl;
   } exp_t;

   exp_t              exp_q[$];
   int                err_q[$];
   exp_t              cur_exp;
   exp_t              mon_e;
   logic [7:0][4:0]   segs [12];
   logic [255:0]      mv;
   logic [255:0][5:0] mp0;
   logic [255:0][5:0] mp1;
   int                total;
   int                bad;
   int                cyc;
   int                hs_total;
   int                rs;

   aim_matcher #(.MATCH_LAST(0), .BATCH_W(4)) dut_first (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_batch(batch), .i_num_seg(num_seg),
      .i_word(word), .i_ia_valid(ia_valid), .o_ia_ready(ia_ready0), .i_ia(ia),
      .i_clear(clear), .o_busy(busy0), .o_done(done0), .o_err(err0), .o_hits(hits0),
      .o_valid(valid0), .o_pos(pos0)
   );

   aim_matcher #(.MATCH_LAST(1), .BATCH_W(4)) dut_last (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_batch(batch), .i_num_seg(num_seg),
      .i_word(word), .i_ia_valid(ia_valid), .o_ia_ready(ia_ready1), .i_ia(ia),
      .i_clear(clear), .o_busy(busy1), .o_done(done1), .o_err(err1), .o_hits(hits1),
      .o_valid(valid1), .o_pos(pos1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (ia_valid && ia_ready0) hs_total <= hs_total + 1;
   end

   task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h exp=%0h", name, act, exp);
      end
   endtask

   // The model bank follows reset, idle clears and every commit popped from the queue.
   always @(negedge clk) begin
      if (rst) begin
         mv  = '0;
         mp0 = '0;
         mp1 = '0;
      end else if (clear && !busy0) begin
         mv  = '0;
         mp0 = '0;
         mp1 = '0;
      end
      if (done0 === 1'b1) begin
         checkOutput("done_expected", 192'(exp_q.size() != 0), 192'(1));
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("done_cycle", 192'(cyc), 192'(mon_e.done_cyc));
            checkOutput("done_both", 192'(done1), 192'(1));
            for (int j = 0; j < 32; j++) begin
               mv[mon_e.batch*32 + j]  = mon_e.vmask[j];
               mp0[mon_e.batch*32 + j] = mon_e.pf[j];
               mp1[mon_e.batch*32 + j] = mon_e.pl[j];
            end
            checkOutput("hits_first", 192'(hits0), 192'($countones(mon_e.vmask)));
            checkOutput("hits_last", 192'(hits1), 192'($countones(mon_e.vmask)));
            for (int k = 0; k < 8; k++) begin
               checkOutput($sformatf("valid_first_slot%0d", k), 192'(valid0[k*32 +: 32]), 192'(mv[k*32 +: 32]));
               checkOutput($sformatf("valid_last_slot%0d", k), 192'(valid1[k*32 +: 32]), 192'(mv[k*32 +: 32]));
               checkOutput($sformatf("pos_first_slot%0d", k), pos0[k*32 +: 32], mp0[k*32 +: 32]);
               checkOutput($sformatf("pos_last_slot%0d", k), pos1[k*32 +: 32], mp1[k*32 +: 32]);
            end
         end
      end
      if (err0 === 1'b1) begin
         checkOutput("err_expected", 192'(err_q.size() != 0), 192'(1));
         if (err_q.size() != 0) begin
            checkOutput("err_cycle", 192'(cyc), 192'(err_q.pop_front()));
            checkOutput("err_both", 192'(err1), 192'(1));
         end
      end
   end

   task automatic resetVec();
      for (int j = 0; j < 32; j++) word[j] = 5'd31;
      for (int k = 0; k < 12; k++) begin
         for (int c = 0; c < 8; c++) segs[k][c] = 5'd30;
      end
      cur_exp.vmask = '0;
      cur_exp.pf    = '0;
      cur_exp.pl    = '0;
   endtask

   task automatic addHit(input int lane, input int pf, input int pl);
      cur_exp.vmask[lane] = 1'b1;
      cur_exp.pf[lane]    = 6'(pf);
      cur_exp.pl[lane]    = 6'(pl);
   endtask

   // Starts a batch, pushes its expected commit, then feeds segments until idle.
   task automatic applyStimulus(input int b, input int ns, input int lat, input int exp_hs,
                                input int gap_at, input int gap_len);
      int   hs;
      int   to;
      int   hs0;
      logic fire;
      @(negedge clk);
      start            = 1'b1;
      batch            = 4'(b);
      num_seg          = 4'(ns);
      cur_exp.batch    = b;
      cur_exp.done_cyc = cyc + lat;
      exp_q.push_back(cur_exp);
      hs0 = hs_total;
      @(negedge clk);
      start = 1'b0;
      hs = 0;
      to = 0;
      while (busy0 && to < 200) begin
         ia       = segs[(hs < 12) ? hs : 11];
         ia_valid = 1'b1;
         fire     = ia_ready0;
         @(negedge clk);
         to++;
         if (fire) begin
            hs++;
            if (hs == gap_at) begin
               ia_valid = 1'b0;
               repeat (2) @(negedge clk);
               for (int g = 0; g < gap_len; g++) begin
                  if (g == 0) clear = 1'b1;
                  if (g == 2) clear = 1'b0;
                  checkOutput("ready_in_gap", 192'(ia_ready0), 192'(1));
                  @(negedge clk);
               end
               clear = 1'b0;
            end
         end
      end
      ia_valid = 1'b0;
      checkOutput("batch_finished", 192'(to < 200), 192'(1));
      checkOutput("handshakes", 192'(hs_total - hs0), 192'(exp_hs));
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; hs_total = 0;
      rst = 1'b1; start = 1'b0; batch = '0; num_seg = '0; ia_valid = 1'b0; ia = '0; clear = 1'b0;
      resetVec();
      repeat (2) @(negedge clk);
      checkOutput("rst_valid", 192'(|valid0), 192'(0));
      checkOutput("rst_pos", 192'(|pos1), 192'(0));
      checkOutput("rst_hits", 192'(hits0), 192'(0));
      checkOutput("rst_busy", 192'(busy0), 192'(0));
      checkOutput("rst_ready", 192'(ia_ready0), 192'(0));
      checkOutput("rst_done_err", 192'({done0, err0}), 192'(0));
      rst = 1'b0;

      $display("[TB] single segment");
      resetVec();
      word[0] = 5'd5;
      segs[0][0] = 5'd3;
      for (int c = 1; c < 8; c++) segs[0][c] = 5'd5;
      addHit(0, 1, 7);
      applyStimulus(0, 1, 5, 1, 0, 0);

      $display("[TB] multi segment priority");
      resetVec();
      word[2] = 5'd9; word[5] = 5'd7; word[10] = 5'd30;
      segs[0][2] = 5'd7; segs[0][6] = 5'd7;
      segs[1][3] = 5'd9;
      segs[2][0] = 5'd9; segs[2][7] = 5'd7;
      addHit(2, 11, 16);
      addHit(5, 2, 23);
      addHit(10, 0, 22);
      applyStimulus(0, 3, 11, 3, 0, 0);

      $display("[TB] idle clear");
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      checkOutput("clear_valid", 192'(|valid0), 192'(0));
      checkOutput("clear_hits", 192'(hits0), 192'(0));
      checkOutput("clear_pos_first", pos0[31:0], 192'(0));
      checkOutput("clear_pos_last", pos1[31:0], 192'(0));
      @(negedge clk);
      clear = 1'b0;

      $display("[TB] slot isolation");
      resetVec();
      word[0] = 5'd4;
      segs[0][5] = 5'd4;
      addHit(0, 5, 5);
      applyStimulus(1, 1, 5, 1, 0, 0);
      resetVec();
      word[31] = 5'd12;
      segs[1][1] = 5'd12; segs[1][4] = 5'd12;
      addHit(31, 9, 12);
      applyStimulus(3, 2, 8, 2, 0, 0);

      $display("[TB] backpressure with busy clear");
      resetVec();
      word[7] = 5'd1;
      segs[0][0] = 5'd1; segs[1][7] = 5'd1;
      addHit(7, 0, 15);
      applyStimulus(2, 2, 12, 2, 1, 4);

      $display("[TB] zero segments");
      resetVec();
      word[0] = 5'd30;
      applyStimulus(4, 0, 2, 0, 0, 0);

      $display("[TB] segment clamp");
      resetVec();
      word[3] = 5'd17; word[4] = 5'd18;
      segs[7][1] = 5'd17; segs[8][0] = 5'd17;
      segs[0][7] = 5'd18; segs[7][7] = 5'd18;
      addHit(3, 57, 57);
      addHit(4, 7, 63);
      applyStimulus(5, 12, 26, 8, 0, 0);

      $display("[TB] out of range batch");
      @(negedge clk);
      start = 1'b1; batch = 4'd8; num_seg = 4'd1;
      err_q.push_back(cyc + 1);
      @(negedge clk);
      start = 1'b0;
      checkOutput("err_stays_idle", 192'(busy0), 192'(0));
      @(negedge clk);
      checkOutput("err_one_pulse", 192'(err0), 192'(0));
      checkOutput("err_bank_kept", 192'(valid0), 192'(mv));

      $display("[TB] reset mid batch");
      resetVec();
      word[1] = 5'd6;
      segs[0][0] = 5'd6;
      @(negedge clk);
      start = 1'b1; batch = 4'd6; num_seg = 4'd3; ia = segs[0];
      rs = cyc;
      @(negedge clk);
      start = 1'b0; ia_valid = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("busy_before_rst", 192'(busy0 && (cyc == rs + 6)), 192'(1));
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_mid_valid", 192'(|valid0), 192'(0));
      checkOutput("rst_mid_pos", pos0[191:160], 192'(0));
      checkOutput("rst_mid_hits", 192'(hits1), 192'(0));
      checkOutput("rst_mid_busy", 192'(busy0), 192'(0));
      @(negedge clk);
      rst = 1'b0; ia_valid = 1'b0;
      repeat (8) @(negedge clk);

      $display("[TB] start after reset");
      resetVec();
      word[0] = 5'd5;
      segs[0][0] = 5'd3;
      for (int c = 1; c < 8; c++) segs[0][c] = 5'd5;
      addHit(0, 1, 7);
      applyStimulus(7, 1, 5, 1, 0, 0);

      repeat (4) @(negedge clk);
      checkOutput("pending_done", 192'(exp_q.size()), 192'(0));
      checkOutput("pending_err", 192'(err_q.size()), 192'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aim_matcher.md
Name: aim_matcher

Overview:
- Parametrised associative index matcher, second generation of the word/IA match stage.
- Compares a batch of LANES weight words against incoming activation segments of IA_CH channels. Records, per word, whether any channel matched and the global channel index of the match.
- Results are committed into a batch slot of an N_WORDS-deep result bank that downstream gather logic reads.
- New over the previous generation:
  - streaming segment handshake;
  - a selectable first/last-match policy, with deterministic priority encoding when several channels match;
  - per-batch hit count;
  - error reporting on bad requests.

Parameters:
- W_BW, 5, bit width of a word and of an IA channel value.
- LANES, 32, words compared in parallel per batch.
- N_WORDS, 256, result bank depth; must be a multiple of LANES.
- IA_CH, 8, IA channels per segment.
- MAX_SEG, 8, maximum segments per batch.
- MATCH_LAST, 0, 0 = the earliest global channel index wins; 1 = the latest wins.
- POS_W, $clog2(MAX_SEG*IA_CH), width of a match position.
- BATCH_W, $clog2(N_WORDS/LANES) (min 1), width of a batch index.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  begin a batch; sampled only in IDLE
- i_batch  in  BATCH_W  destination slot; the words it covers are batch*LANES .. batch*LANES+LANES-1
- i_num_seg  in  $clog2(MAX_SEG)+1  number of segments to consume
- i_word  in  LANES x W_BW  words; latched on an accepted start
- i_ia_valid  in  1  segment valid
- o_ia_ready  out  1  segment ready
- i_ia  in  IA_CH x W_BW  segment channel values
- i_clear  in  1  synchronous clear of the result bank
- o_busy  out  1  high whenever not IDLE
- o_done  out  1  one-cycle pulse: the batch is committed
- o_err  out  1  one-cycle pulse: the start was rejected
- o_hits  out  $clog2(LANES)+1  number of valid lanes in the last committed batch
- o_valid  out  N_WORDS x 1  per-word match flag
- o_pos  out  N_WORDS x POS_W  per-word match position

Behaviour:
- Reset (async, i_rst=1):
  - state IDLE;
  - o_valid, o_pos, o_hits, o_done, o_err all 0;
  - o_ia_ready 0; scratch and counters 0.
  - Reset mid-batch aborts the batch. No commit and no o_done.
- State machine: IDLE, WAIT_SEG, COMP, ENC, COMMIT.
- IDLE:
  - Start accepted (i_start=1 and i_batch < N_WORDS/LANES): latch i_word, i_batch, and num_seg = min(i_num_seg, MAX_SEG); clear scratch and seg_cnt.
  - If num_seg==0, go to COMMIT; otherwise go to WAIT_SEG.
  - Start with i_batch out of range: stay IDLE, pulse o_err next cycle.
  - i_start outside IDLE is ignored; no error is raised.
- WAIT_SEG:
  - o_ia_ready=1.
  - On i_ia_valid & o_ia_ready: latch i_ia and go to COMP.
- COMP: register map[j][c] = (word[j]==ia[c]) for all LANES x IA_CH pairs; go to ENC.
- ENC, per lane:
  - Priority-encode map[j]: lowest set c when MATCH_LAST=0, highest set c when MATCH_LAST=1.
  - cand = seg_cnt*IA_CH + c, computed zero-extended to POS_W.
  - MATCH_LAST=0: write scratch only if scratch_valid[j]==0.
  - MATCH_LAST=1: write scratch whenever the lane has any hit.
  - seg_cnt increments. If seg_cnt+1==num_seg, go to COMMIT; otherwise go to WAIT_SEG.
- COMMIT:
  - Write scratch valid/pos into bank entries batch*LANES+j.
  - o_hits = popcount(scratch_valid).
  - Pulse o_done. Go to IDLE.
  - Bank entries outside the slot are unchanged.
- Outputs o_valid/o_pos/o_hits are registered. o_done is high in the first cycle the new values are visible.
- Latency with i_ia_valid held high: o_done is high 3*num_seg+2 cycles after the start cycle; num_seg=0 gives 2.
- Throughput is one segment per 3 cycles.
- i_clear:
  - In IDLE: zero o_valid/o_pos/o_hits next cycle.
  - Outside IDLE: i_clear is ignored.
  - Same cycle as an accepted start: both actions happen.
- Unmatched lanes commit valid=0, pos=0.
- X/Z values on i_ia never propagate; the comparison is a plain equality on sampled bits.

Decomposition:
- Shared package aim_pkg:
  - state enum aim_state_e;
  - defaults for W_BW, IA_CH, LANES;
  - function clamp_seg;
  - typedef pos_t sized from the POS_W default.
- One sub-module: aim_prio_enc. Parameters IA_CH and MSB_FIRST. Inputs: map vector. Outputs: hit, index.
  - One instance per lane, generated in a loop.
  - The top holds the FSM, scratch, and the result bank.

Test Plan:
- Single segment. word[0]=5, ia={3,5,5,...}, num_seg=1, MATCH_LAST=0, batch 0.
  - o_done 5 cycles after start; o_valid[0]=1, o_pos[0]=1, o_hits=1; other lanes 0.
- Multi-segment, first-match policy. word[2]=9; ia seg0 has no 9; seg1 ch3=9; seg2 ch0=9; num_seg=3.
  - pos[2]=11, done at cycle 11.
  - Rerun with MATCH_LAST=1: pos[2]=16.
- Slot isolation. Commit batch 1, then batch 3.
  - Entries 32-63 hold batch-1 results, 96-127 hold batch-3 results, all others remain 0.
- Backpressure. Drop i_ia_valid for 4 cycles between segments.
  - o_ia_ready stays 1, no segment is skipped, done is delayed by exactly 4 cycles.
- Boundary starts.
  - num_seg=0: done after 2 cycles, slot all-invalid, hits=0.
  - num_seg=12 with MAX_SEG=8: exactly 8 handshakes.
  - i_batch=8 with N_WORDS=256: o_err pulse, state stays IDLE.
- Reset and clear.
  - Assert i_rst during ENC of seg 1: no o_done, all outputs 0, next start behaves normally.
  - i_clear in IDLE zeroes the bank in 1 cycle.
